// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the CPU run controller: FSM state encoding and stop-cause codes.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_READY = 3'd3,
        ST_RUN   = 3'd4,
        ST_STEP  = 3'd5,
        ST_HALT  = 3'd6
    } state_t;

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_SELFLOOP = 2'd1;
    localparam logic [1:0] CAUSE_BUDGET   = 2'd2;
    localparam logic [1:0] CAUSE_STOP     = 2'd3;

endpackage

// File: rtl/cpu_halt_detector.sv
// Remembers the PC seen on the previous enabled cycle and flags a self-loop when
// the CPU presents the same PC again, meaning the program jumped to itself.
module cpu_halt_detector #(
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_capture,
    input  logic [ADDR_W-1:0] i_pc,
    output logic              o_self_loop
);

    logic [ADDR_W-1:0] r_pc_q;
    logic              r_pc_q_valid;

    // Capture the PC on every enabled cycle; clear at the start of each run
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_pc_q       <= '0;
            r_pc_q_valid <= 1'b0;
        end else if (i_capture) begin
            r_pc_q       <= i_pc;
            r_pc_q_valid <= 1'b1;
        end
    end

    assign o_self_loop = r_pc_q_valid && (i_pc == r_pc_q);

endmodule

// File: rtl/cpu_run_controller.sv
// Host-side sequencer for the 3-bit CPU: clears it, streams a program into its RAM,
// then gates PC_Enable for free-run, budgeted run or single-step.
module cpu_run_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = 3,
    parameter int unsigned INSTR_W = 9,
    parameter int unsigned CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_start,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               load_last,
    input  logic               run_start,
    input  logic               step_req,
    input  logic               stop_req,
    input  logic [CNT_W-1:0]   max_cycles,
    input  logic [ADDR_W-1:0]  cpu_pc,
    output logic               cpu_reset,
    output logic               pc_enable,
    output logic               ram_we,
    output logic [ADDR_W-1:0]  ram_waddr,
    output logic [INSTR_W-1:0] ram_wdata,
    output logic               busy,
    output logic               halted,
    output logic [1:0]         done_cause,
    output logic [CNT_W-1:0]   cycle_count
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             r_state;
    state_t             w_next_state;
    logic [ADDR_W-1:0]  r_addr;
    logic [CNT_W-1:0]   r_cycle_count;
    logic [1:0]         r_done_cause;

    logic               w_self_loop;
    logic               w_budget_hit;
    logic               w_stop;
    logic [1:0]         w_stop_cause;
    logic               w_accept;
    logic               w_load_end;
    logic               w_idle_like;
    logic               w_run_go;
    logic               w_step_go;
    logic               w_run_enable;
    logic               w_pc_clear;
    logic [CNT_W-1:0]   w_cnt_inc;

    // READY and HALT behave the same way towards host commands; load_start outranks run_start
    assign w_idle_like = (r_state == ST_READY) || (r_state == ST_HALT);
    assign w_run_go    = w_idle_like && !load_start && run_start;
    assign w_step_go   = w_idle_like && !load_start && !run_start && step_req;

    assign w_accept     = (r_state == ST_LOAD) && load_valid;
    assign w_load_end   = w_accept && (load_last || (r_addr == ADDR_MAX));
    assign w_budget_hit = (max_cycles != '0) && (r_cycle_count == max_cycles);
    assign w_cnt_inc    = (r_cycle_count == CNT_MAX) ? CNT_MAX : (r_cycle_count + CNT_ONE);

    // Stop-condition priority: host stop, then self-loop, then budget expiry
    always_comb begin
        w_stop       = 1'b0;
        w_stop_cause = CAUSE_NONE;
        if (stop_req) begin
            w_stop       = 1'b1;
            w_stop_cause = CAUSE_STOP;
        end else if (w_self_loop) begin
            w_stop       = 1'b1;
            w_stop_cause = CAUSE_SELFLOOP;
        end else if (w_budget_hit) begin
            w_stop       = 1'b1;
            w_stop_cause = CAUSE_BUDGET;
        end
    end

    assign w_run_enable = (r_state == ST_RUN) && !w_stop;
    assign w_pc_clear   = w_run_go || (r_state == ST_CLEAR);

    cpu_halt_detector #(
        .ADDR_W (ADDR_W)
    ) u_halt_detector (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (w_pc_clear),
        .i_capture   (w_run_enable),
        .i_pc        (cpu_pc),
        .o_self_loop (w_self_loop)
    );

    // Next-state selection for the sequencer
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (load_start) w_next_state = ST_CLEAR;
            ST_CLEAR: w_next_state = ST_LOAD;
            ST_LOAD:  if (w_load_end) w_next_state = ST_READY;
            ST_READY, ST_HALT: begin
                if (load_start)     w_next_state = ST_CLEAR;
                else if (run_start) w_next_state = ST_RUN;
                else if (step_req)  w_next_state = ST_STEP;
            end
            ST_RUN:   if (w_stop) w_next_state = ST_HALT;
            ST_STEP:  w_next_state = ST_READY;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // State register plus address counter, cycle counter and stop-cause bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_addr        <= '0;
            r_cycle_count <= '0;
            r_done_cause  <= CAUSE_NONE;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_CLEAR: begin
                    r_addr        <= '0;
                    r_cycle_count <= '0;
                    r_done_cause  <= CAUSE_NONE;
                end
                ST_LOAD: begin
                    if (w_accept && (r_addr != ADDR_MAX)) r_addr <= r_addr + 1'b1;
                end
                ST_READY, ST_HALT: begin
                    if (w_run_go) begin
                        r_cycle_count <= '0;
                        r_done_cause  <= CAUSE_NONE;
                    end else if (w_step_go) begin
                        r_done_cause  <= CAUSE_NONE;
                    end
                end
                ST_RUN: begin
                    if (w_stop) r_done_cause <= w_stop_cause;
                    else        r_cycle_count <= w_cnt_inc;
                end
                ST_STEP: begin
                    r_cycle_count <= w_cnt_inc;
                end
                default: ;
            endcase
        end
    end

    assign cpu_reset   = reset || (r_state == ST_CLEAR);
    assign load_ready  = (r_state == ST_LOAD);
    assign ram_we      = load_valid && load_ready && !reset;
    assign ram_waddr   = r_addr;
    assign ram_wdata   = load_ready ? load_data : '0;
    assign pc_enable   = (w_run_enable || (r_state == ST_STEP)) && !reset;
    assign busy        = (r_state == ST_CLEAR) || (r_state == ST_LOAD) ||
                         (r_state == ST_RUN)   || (r_state == ST_STEP);
    assign halted      = (r_state == ST_HALT);
    assign done_cause  = r_done_cause;
    assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Scoreboard bench for cpu_run_controller driving a tiny behavioural CPU model.
// RAM writes and end-of-activity records are queued as expectations and checked by a monitor.
module tb_cpu_run_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_start, load_valid, load_last, run_start, step_req, stop_req;
    logic [8:0] load_data;
    logic [7:0] max_cycles;
    logic [2:0] cpu_pc;
    logic       load_ready, cpu_reset, pc_enable, ram_we, busy, halted;
    logic [2:0] ram_waddr;
    logic [8:0] ram_wdata;
    logic [1:0] done_cause;
    logic [7:0] cycle_count;

    int checks = 0;
    int errors = 0;

    logic [11:0] wrQ[$];
    logic [21:0] doneQ[$];
    logic [8:0]  prog[9];

    logic [8:0]  cpuMem[8];
    logic [2:0]  cpuPcReg;

    cpu_run_controller dut (
        .clk(clk), .reset(reset), .load_start(load_start), .load_valid(load_valid),
        .load_ready(load_ready), .load_data(load_data), .load_last(load_last),
        .run_start(run_start), .step_req(step_req), .stop_req(stop_req),
        .max_cycles(max_cycles), .cpu_pc(cpu_pc), .cpu_reset(cpu_reset),
        .pc_enable(pc_enable), .ram_we(ram_we), .ram_waddr(ram_waddr),
        .ram_wdata(ram_wdata), .busy(busy), .halted(halted),
        .done_cause(done_cause), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    // Behavioural CPU: opcode 3'b111 in bits [8:6] jumps to bits [2:0], anything else advances
    always @(posedge clk) begin
        if (cpu_reset) begin
            cpuPcReg <= 3'd0;
            for (int i = 0; i < 8; i++) cpuMem[i] <= 9'd0;
        end else begin
            if (ram_we) cpuMem[ram_waddr] <= ram_wdata;
            if (pc_enable) begin
                if (cpuMem[cpuPcReg][8:6] == 3'b111) cpuPcReg <= cpuMem[cpuPcReg][2:0];
                else                                 cpuPcReg <= cpuPcReg + 3'd1;
            end
        end
    end
    assign cpu_pc = cpuPcReg;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ls, input logic rs, input logic sr);
        load_start = ls;
        run_start  = rs;
        step_req   = sr;
        tick();
        load_start = 1'b0;
        run_start  = 1'b0;
        step_req   = 1'b0;
    endtask

    task automatic sendWord(input logic [8:0] data, input logic last);
        load_valid = 1'b1;
        load_data  = data;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        if (busy !== 1'b0) begin
            checks++;
            errors++;
            $display("[TB] FAIL waitIdle timeout busy=%b expected=0", busy);
        end
        tick();
    endtask

    // Record layout: {halted, done_cause, cycle_count, cpu_pc, enabled cycles}
    function automatic logic [21:0] mkDone(input logic h, input logic [1:0] c,
                                           input logic [7:0] cnt, input logic [2:0] pc,
                                           input logic [7:0] en);
        return {h, c, cnt, pc, en};
    endfunction

    task automatic loadProgram(input int n, input bit useLast);
        doneQ.push_back(mkDone(1'b0, 2'd0, 8'd0, 3'd0, 8'd0));
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("cpu_reset in CLEAR", {31'd0, cpu_reset}, 32'd1);
        tick();
        checkOutput("cpu_reset in LOAD", {31'd0, cpu_reset}, 32'd0);
        for (int i = 0; i < n; i++) begin
            if (i < 8) wrQ.push_back({i[2:0], prog[i]});
            if (i == 8) checkOutput("load_ready after 8th word", {31'd0, load_ready}, 32'd0);
            sendWord(prog[i], useLast && (i == n - 1));
        end
        waitIdle(20);
    endtask

    initial begin
        int enCount;
        logic prevBusy;
        logic [11:0] expW;
        logic [21:0] expD;

        reset = 1'b1; load_start = 0; load_valid = 0; load_last = 0; load_data = 0;
        run_start = 0; step_req = 0; stop_req = 0; max_cycles = 0;
        enCount = 0; prevBusy = 1'b0;

        fork
            // Monitor: pop expectations whenever the DUT writes RAM or finishes an activity
            forever begin
                @(negedge clk);
                if (busy === 1'b1 && prevBusy !== 1'b1) enCount = 0;
                if (pc_enable === 1'b1) enCount++;
                if (ram_we === 1'b1) begin
                    if (wrQ.size() == 0) begin
                        checks++; errors++;
                        $display("[TB] FAIL unexpected write addr=%0d data=%h", ram_waddr, ram_wdata);
                    end else begin
                        expW = wrQ.pop_front();
                        checkOutput("ram write {addr,data}", {20'd0, ram_waddr, ram_wdata}, {20'd0, expW});
                    end
                end
                if (busy === 1'b0 && prevBusy === 1'b1) begin
                    if (doneQ.size() == 0) begin
                        checks++; errors++;
                        $display("[TB] FAIL unexpected completion halted=%b cause=%0d", halted, done_cause);
                    end else begin
                        expD = doneQ.pop_front();
                        checkOutput("completion {halt,cause,cnt,pc,en}",
                                    {10'd0, halted, done_cause, cycle_count, cpu_pc, enCount[7:0]},
                                    {10'd0, expD});
                    end
                end
                prevBusy = busy;
            end
        join_none

        // Reset state
        tick(); tick();
        checkOutput("reset cpu_reset", {31'd0, cpu_reset}, 32'd1);
        checkOutput("reset outputs", {21'd0, load_ready, pc_enable, ram_we, busy, halted, done_cause, cycle_count[3:0]}, 32'd0);
        checkOutput("reset cycle_count", {24'd0, cycle_count}, 32'd0);
        reset = 1'b0;
        tick();
        checkOutput("idle cpu_reset", {31'd0, cpu_reset}, 32'd0);

        // Test 1: three words ending with load_last
        prog[0] = 9'h0A5; prog[1] = 9'h05A; prog[2] = 9'h133;
        loadProgram(3, 1'b1);
        checkOutput("ready after load", {30'd0, busy, halted}, 32'd0);

        // Test 3: NOP, NOP, JMP 2 -> self-loop after 3 enabled cycles
        prog[0] = 9'h000; prog[1] = 9'h000; prog[2] = 9'h1C2;
        loadProgram(3, 1'b1);
        max_cycles = 8'd0;
        doneQ.push_back(mkDone(1'b1, 2'd1, 8'd3, 3'd2, 8'd3));
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitIdle(100);

        // Test 4: NOP, JMP 0 loops forever; budget of 5 enabled cycles
        prog[0] = 9'h000; prog[1] = 9'h1C0;
        loadProgram(2, 1'b1);
        max_cycles = 8'd5;
        doneQ.push_back(mkDone(1'b1, 2'd2, 8'd5, 3'd1, 8'd5));
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitIdle(100);
        max_cycles = 8'd0;

        // Test 2: nine words, no load_last -> only addresses 0..7 are written
        for (int i = 0; i < 9; i++) prog[i] = 9'h010 + 9'(i);
        loadProgram(9, 1'b0);

        // Test 5: stop during RUN, then a single step from HALT
        doneQ.push_back(mkDone(1'b1, 2'd3, 8'd2, 3'd2, 8'd2));
        applyStimulus(1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("pc_enable while running", {31'd0, pc_enable}, 32'd1);
        tick();
        stop_req = 1'b1;
        #1;
        checkOutput("pc_enable on stop_req", {31'd0, pc_enable}, 32'd0);
        tick();
        stop_req = 1'b0;
        waitIdle(20);
        doneQ.push_back(mkDone(1'b0, 2'd0, 8'd3, 3'd3, 8'd1));
        applyStimulus(1'b0, 1'b0, 1'b1);
        waitIdle(20);

        // Test 6: reset after two words of a load aborts to IDLE
        for (int i = 0; i < 2; i++) wrQ.push_back({i[2:0], prog[i]});
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        sendWord(prog[0], 1'b0);
        sendWord(prog[1], 1'b0);
        doneQ.push_back(mkDone(1'b0, 2'd0, 8'd0, 3'd0, 8'd0));
        reset = 1'b1;
        tick();
        checkOutput("abort ram_we", {31'd0, ram_we}, 32'd0);
        checkOutput("abort cpu_reset", {31'd0, cpu_reset}, 32'd1);
        checkOutput("abort load_ready", {31'd0, load_ready}, 32'd0);
        checkOutput("abort busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        tick();
        checkOutput("idle after abort cpu_reset", {31'd0, cpu_reset}, 32'd0);
        tick();

        checkOutput("write queue drained", wrQ.size(), 32'd0);
        checkOutput("completion queue drained", doneQ.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
